// File: rtl/fifo_frame_buffer.sv
// fifo_frame_buffer: packs FWFT FIFO samples into ping-pong frames with per-frame energy
module fifo_frame_buffer #(
   parameter int B  = 8,
   parameter int AW = 8,
   parameter int EW = 2*B+AW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          fifo_empty,
   input  logic [B-1:0]  fifo_r_data,
   output logic          fifo_rd,
   output logic          frame_valid,
   output logic          frame_bank,
   output logic [EW-1:0] frame_energy,
   input  logic [AW-1:0] rd_addr,
   output logic [B-1:0]  rd_data,
   input  logic          frame_done,
   output logic          busy
);
   typedef enum logic [1:0] {IDLE, FILL, STALL} state_t;
   state_t state_q, state_d;
   logic fill_bank_q, fill_bank_d, rd_bank_q, rd_bank_d;
   logic [1:0] bank_full_q, bank_full_d;
   logic [AW-1:0] wr_idx_q, wr_idx_d;
   logic [EW-1:0] acc_q, acc_d;
   logic [EW-1:0] energy_q [2];
   logic [EW-1:0] energy_d [2];
   logic [B-1:0] rd_data_q, rd_data_d;
   logic [B-1:0] mem_q [2**(AW+1)];
   logic signed [2*B-1:0] samp_x, sq;
   logic last, rel;
   assign samp_x       = {{B{fifo_r_data[B-1]}}, fifo_r_data};
   assign sq           = samp_x * samp_x;
   assign fifo_rd      = enable & (state_q == FILL) & ~fifo_empty & ~bank_full_q[fill_bank_q];
   assign last         = fifo_rd & (wr_idx_q == '1);
   assign rel          = frame_done & bank_full_q[rd_bank_q];
   assign frame_valid  = bank_full_q[rd_bank_q];
   assign frame_bank   = rd_bank_q;
   assign frame_energy = energy_q[rd_bank_q];
   assign rd_data      = rd_data_q;
   assign busy         = state_q != IDLE;
   always_comb begin
      fill_bank_d = fill_bank_q;
      rd_bank_d   = rd_bank_q ^ rel;
      bank_full_d = bank_full_q;
      wr_idx_d    = wr_idx_q;
      acc_d       = acc_q;
      energy_d    = energy_q;
      rd_data_d   = mem_q[{rd_bank_q, rd_addr}];
      if (rel) bank_full_d[rd_bank_q] = 1'b0;
      if (fifo_rd) begin
         wr_idx_d = wr_idx_q + AW'(1);
         acc_d    = acc_q + EW'($unsigned(sq));
      end
      // completion and release can land together; they always touch different banks
      if (last) begin
         energy_d[fill_bank_q]    = acc_d;
         bank_full_d[fill_bank_q] = 1'b1;
         acc_d                    = '0;
         fill_bank_d              = ~fill_bank_q;
      end
      if (!enable) begin
         wr_idx_d = '0;
         acc_d    = '0;
      end
      state_d = !enable              ? IDLE :
                state_q == IDLE      ? FILL :
                state_q == STALL     ? (bank_full_q[fill_bank_q] ? STALL : FILL) :
                (last && bank_full_d[~fill_bank_q]) ? STALL : FILL;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         fill_bank_q <= 1'b0;
         rd_bank_q   <= 1'b0;
         bank_full_q <= '0;
         wr_idx_q    <= '0;
         acc_q       <= '0;
         energy_q    <= '{default: '0};
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         fill_bank_q <= fill_bank_d;
         rd_bank_q   <= rd_bank_d;
         bank_full_q <= bank_full_d;
         wr_idx_q    <= wr_idx_d;
         acc_q       <= acc_d;
         energy_q    <= energy_d;
         rd_data_q   <= rd_data_d;
      end
   end
   always_ff @(posedge clk) begin
      if (fifo_rd) mem_q[{fill_bank_q, wr_idx_q}] <= fifo_r_data;
   end
endmodule

// File: tb/tb_fifo_frame_buffer.sv
// tb_fifo_frame_buffer: directed scenarios against a simple FWFT FIFO model, B=8 AW=2
module tb_fifo_frame_buffer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic fifo_empty, fifo_rd, frame_valid, frame_bank, frame_done = 1'b0, busy;
   logic [7:0] fifo_r_data, rd_data;
   logic [17:0] frame_energy;
   logic [1:0] rd_addr = '0;
   logic [7:0] fmem [64];
   int wp = 0, rp = 0, s = 0;
   int checks = 0, failures = 0;

   fifo_frame_buffer #(.B(8), .AW(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_r_data(fifo_r_data), .fifo_rd(fifo_rd), .frame_valid(frame_valid),
      .frame_bank(frame_bank), .frame_energy(frame_energy), .rd_addr(rd_addr),
      .rd_data(rd_data), .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;
   assign fifo_empty  = (wp == rp);
   assign fifo_r_data = fmem[rp % 64];
   always @(posedge clk) if (fifo_rd) rp <= rp + 1;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] v);
      fmem[wp % 64] = v;
      wp++;
   endtask

   task automatic release_frame();
      frame_done = 1'b1;
      tick(1);
      frame_done = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; frame_done = 1'b0; rd_addr = '0;
      wp = rp;
      tick(1);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      tick(2);
      reset = 1'b0;
      if (fifo_rd !== 1'b0) begin $display("FAIL reset_fifo_rd got=%b exp=0", fifo_rd); failures++; end checks++;
      if (frame_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", frame_valid); failures++; end checks++;
      if (frame_bank !== 1'b0) begin $display("FAIL reset_bank got=%b exp=0", frame_bank); failures++; end checks++;
      if (frame_energy !== 18'd0) begin $display("FAIL reset_energy got=%0d exp=0", frame_energy); failures++; end checks++;
      if (rd_data !== 8'd0) begin $display("FAIL reset_rd_data got=%0d exp=0", rd_data); failures++; end checks++;
      if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); failures++; end checks++;
   endtask

   task automatic test_basic();
      enable = 1'b1;
      s = rp;
      for (int i = 1; i <= 4; i++) push(8'(i));
      tick(1);
      if (busy !== 1'b1) begin $display("FAIL basic_busy got=%b exp=1", busy); failures++; end checks++;
      if (fifo_rd !== 1'b1) begin $display("FAIL basic_first_rd got=%b exp=1", fifo_rd); failures++; end checks++;
      tick(3);
      if (frame_valid !== 1'b0) begin $display("FAIL basic_early_valid got=%b exp=0", frame_valid); failures++; end checks++;
      if (rp - s !== 3) begin $display("FAIL basic_pops3 got=%0d exp=3", rp - s); failures++; end checks++;
      tick(1);
      if (frame_valid !== 1'b1) begin $display("FAIL basic_valid got=%b exp=1", frame_valid); failures++; end checks++;
      if (frame_bank !== 1'b0) begin $display("FAIL basic_bank got=%b exp=0", frame_bank); failures++; end checks++;
      if (frame_energy !== 18'd30) begin $display("FAIL basic_energy got=%0d exp=30", frame_energy); failures++; end checks++;
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i);
         tick(1);
         if (rd_data !== 8'(i + 1)) begin $display("FAIL basic_rd_data[%0d] got=%0d exp=%0d", i, rd_data, i + 1); failures++; end checks++;
      end
      release_frame();
      if (frame_valid !== 1'b0) begin $display("FAIL basic_after_done_valid got=%b exp=0", frame_valid); failures++; end checks++;
      if (frame_bank !== 1'b1) begin $display("FAIL basic_after_done_bank got=%b exp=1", frame_bank); failures++; end checks++;
   endtask

   task automatic test_negative();
      repeat (4) push(8'h80);
      tick(4);
      if (frame_valid !== 1'b1) begin $display("FAIL neg_valid got=%b exp=1", frame_valid); failures++; end checks++;
      if (frame_bank !== 1'b1) begin $display("FAIL neg_bank got=%b exp=1", frame_bank); failures++; end checks++;
      if (frame_energy !== 18'd65536) begin $display("FAIL neg_energy got=%0d exp=65536", frame_energy); failures++; end checks++;
      rd_addr = 2'd2;
      tick(1);
      if (rd_data !== 8'h80) begin $display("FAIL neg_rd_data got=%h exp=80", rd_data); failures++; end checks++;
      release_frame();
      repeat (4) push(8'h00);
      tick(4);
      if (frame_valid !== 1'b1) begin $display("FAIL zero_valid got=%b exp=1", frame_valid); failures++; end checks++;
      if (frame_bank !== 1'b0) begin $display("FAIL zero_bank got=%b exp=0", frame_bank); failures++; end checks++;
      if (frame_energy !== 18'd0) begin $display("FAIL zero_energy got=%0d exp=0", frame_energy); failures++; end checks++;
      release_frame();
   endtask

   task automatic test_back_pressure();
      do_reset();
      enable = 1'b1;
      s = rp;
      for (int i = 10; i <= 21; i++) push(8'(i));
      tick(11);
      if (rp - s !== 8) begin $display("FAIL bp_pops got=%0d exp=8", rp - s); failures++; end checks++;
      if (wp - rp !== 4) begin $display("FAIL bp_remaining got=%0d exp=4", wp - rp); failures++; end checks++;
      if (fifo_rd !== 1'b0) begin $display("FAIL bp_stall_rd got=%b exp=0", fifo_rd); failures++; end checks++;
      if (busy !== 1'b1) begin $display("FAIL bp_busy got=%b exp=1", busy); failures++; end checks++;
      if (frame_bank !== 1'b0) begin $display("FAIL bp_bank0 got=%b exp=0", frame_bank); failures++; end checks++;
      if (frame_energy !== 18'd534) begin $display("FAIL bp_energy0 got=%0d exp=534", frame_energy); failures++; end checks++;
      release_frame();
      if (frame_bank !== 1'b1) begin $display("FAIL bp_bank1 got=%b exp=1", frame_bank); failures++; end checks++;
      if (frame_valid !== 1'b1) begin $display("FAIL bp_valid1 got=%b exp=1", frame_valid); failures++; end checks++;
      if (frame_energy !== 18'd966) begin $display("FAIL bp_energy1 got=%0d exp=966", frame_energy); failures++; end checks++;
      if (fifo_rd !== 1'b0) begin $display("FAIL bp_still_stalled got=%b exp=0", fifo_rd); failures++; end checks++;
      tick(1);
      if (fifo_rd !== 1'b1) begin $display("FAIL bp_resume got=%b exp=1", fifo_rd); failures++; end checks++;
      tick(4);
      if (rp - s !== 12) begin $display("FAIL bp_all_popped got=%0d exp=12", rp - s); failures++; end checks++;
      if (frame_bank !== 1'b1) begin $display("FAIL bp_hold_bank got=%b exp=1", frame_bank); failures++; end checks++;
   endtask

   task automatic test_back_to_back();
      release_frame();
      if (frame_bank !== 1'b0) begin $display("FAIL b2b_bank0 got=%b exp=0", frame_bank); failures++; end checks++;
      if (frame_energy !== 18'd1526) begin $display("FAIL b2b_energy0 got=%0d exp=1526", frame_energy); failures++; end checks++;
      repeat (4) push(8'd2);
      repeat (4) push(8'd3);
      tick(1);
      if (fifo_rd !== 1'b1) begin $display("FAIL b2b_rd_start got=%b exp=1", fifo_rd); failures++; end checks++;
      tick(3);
      frame_done = 1'b1;
      tick(1);
      frame_done = 1'b0;
      if (fifo_rd !== 1'b1) begin $display("FAIL b2b_no_stall got=%b exp=1", fifo_rd); failures++; end checks++;
      if (frame_valid !== 1'b1) begin $display("FAIL b2b_valid got=%b exp=1", frame_valid); failures++; end checks++;
      if (frame_bank !== 1'b1) begin $display("FAIL b2b_bank1 got=%b exp=1", frame_bank); failures++; end checks++;
      if (frame_energy !== 18'd16) begin $display("FAIL b2b_energy1 got=%0d exp=16", frame_energy); failures++; end checks++;
      tick(4);
      if (fifo_rd !== 1'b0) begin $display("FAIL b2b_stall_rd got=%b exp=0", fifo_rd); failures++; end checks++;
      release_frame();
      if (frame_bank !== 1'b0) begin $display("FAIL b2b_next_bank got=%b exp=0", frame_bank); failures++; end checks++;
      if (frame_energy !== 18'd36) begin $display("FAIL b2b_next_energy got=%0d exp=36", frame_energy); failures++; end checks++;
      release_frame();
      if (frame_valid !== 1'b0) begin $display("FAIL b2b_drained got=%b exp=0", frame_valid); failures++; end checks++;
   endtask

   task automatic test_enable_drop();
      do_reset();
      enable = 1'b1;
      s = rp;
      repeat (4) push(8'd9);
      tick(3);
      if (rp - s !== 2) begin $display("FAIL drop_pops got=%0d exp=2", rp - s); failures++; end checks++;
      enable = 1'b0;
      #1;
      if (fifo_rd !== 1'b0) begin $display("FAIL drop_rd_forced got=%b exp=0", fifo_rd); failures++; end checks++;
      tick(1);
      if (busy !== 1'b0) begin $display("FAIL drop_idle got=%b exp=0", busy); failures++; end checks++;
      wp = rp;
      release_frame();
      if (frame_valid !== 1'b0) begin $display("FAIL drop_ignored_valid got=%b exp=0", frame_valid); failures++; end checks++;
      if (frame_bank !== 1'b0) begin $display("FAIL drop_ignored_bank got=%b exp=0", frame_bank); failures++; end checks++;
      enable = 1'b1;
      for (int i = 5; i <= 8; i++) push(8'(i));
      tick(5);
      if (frame_valid !== 1'b1) begin $display("FAIL drop_valid got=%b exp=1", frame_valid); failures++; end checks++;
      if (frame_bank !== 1'b0) begin $display("FAIL drop_bank got=%b exp=0", frame_bank); failures++; end checks++;
      if (frame_energy !== 18'd174) begin $display("FAIL drop_energy got=%0d exp=174", frame_energy); failures++; end checks++;
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i);
         tick(1);
         if (rd_data !== 8'(i + 5)) begin $display("FAIL drop_rd_data[%0d] got=%0d exp=%0d", i, rd_data, i + 5); failures++; end checks++;
      end
   endtask

   task automatic test_reset_mid();
      s = rp;
      push(8'd1);
      push(8'd2);
      tick(3);
      if (rp - s !== 2) begin $display("FAIL mid_partial got=%0d exp=2", rp - s); failures++; end checks++;
      #2 reset = 1'b1;
      #1;
      if (frame_valid !== 1'b0) begin $display("FAIL mid_valid got=%b exp=0", frame_valid); failures++; end checks++;
      if (frame_energy !== 18'd0) begin $display("FAIL mid_energy got=%0d exp=0", frame_energy); failures++; end checks++;
      if (rd_data !== 8'd0) begin $display("FAIL mid_rd_data got=%0d exp=0", rd_data); failures++; end checks++;
      if (busy !== 1'b0) begin $display("FAIL mid_busy got=%b exp=0", busy); failures++; end checks++;
      if (fifo_rd !== 1'b0) begin $display("FAIL mid_fifo_rd got=%b exp=0", fifo_rd); failures++; end checks++;
      tick(1);
      reset = 1'b0;
      wp = rp;
      repeat (4) push(8'd3);
      tick(5);
      if (frame_valid !== 1'b1) begin $display("FAIL mid_refill_valid got=%b exp=1", frame_valid); failures++; end checks++;
      if (frame_bank !== 1'b0) begin $display("FAIL mid_refill_bank got=%b exp=0", frame_bank); failures++; end checks++;
      if (frame_energy !== 18'd36) begin $display("FAIL mid_refill_energy got=%0d exp=36", frame_energy); failures++; end checks++;
      rd_addr = 2'd0;
      tick(1);
      if (rd_data !== 8'd3) begin $display("FAIL mid_refill_rd got=%0d exp=3", rd_data); failures++; end checks++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_back_pressure();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
